// File: rtl/gray_stream_decoder_if.sv
// Gray sample stream in, decoded value / step classification / counters out.
interface gray_stream_decoder_if #(
  parameter int unsigned WIDTH     = 4,
  parameter int unsigned POS_W     = 16,
  parameter int unsigned ERR_CNT_W = 8
);
  logic                 gray_valid;
  logic [WIDTH-1:0]     gray_in;
  logic                 clear;
  logic [WIDTH-1:0]     binary_out;
  logic                 binary_valid;
  logic                 step_up;
  logic                 step_down;
  logic                 step_err;
  logic                 locked;
  logic [POS_W-1:0]     pos_count;
  logic [ERR_CNT_W-1:0] err_count;

  modport master (
    output gray_valid, gray_in, clear,
    input  binary_out, binary_valid, step_up, step_down, step_err,
           locked, pos_count, err_count
  );

  modport slave (
    input  gray_valid, gray_in, clear,
    output binary_out, binary_valid, step_up, step_down, step_err,
           locked, pos_count, err_count
  );
endinterface

// File: rtl/gray_stream_decoder.sv
// Decodes a Gray sample stream to binary, classifies each sample against the
// previous one (up/down/illegal) and keeps a signed position and error count.
module gray_stream_decoder #(
  parameter int unsigned WIDTH     = 4,
  parameter int unsigned POS_W     = 16,
  parameter int unsigned ERR_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  gray_stream_decoder_if.slave bus
);

  localparam logic [ERR_CNT_W-1:0] ERR_MAX = '1;

  typedef enum logic {UNLOCKED = 1'b0, LOCKED = 1'b1} state_t;

  state_t               state_q, state_d;
  logic [WIDTH-1:0]     ref_q, ref_d;
  logic                 bv_q, bv_d;
  logic                 up_q, up_d;
  logic                 dn_q, dn_d;
  logic                 er_q, er_d;
  logic [POS_W-1:0]     pos_q, pos_d;
  logic [ERR_CNT_W-1:0] err_q, err_d;
  logic [WIDTH-1:0]     sample;

  function automatic logic [WIDTH-1:0] gray2bin(input logic [WIDTH-1:0] g);
    logic [WIDTH-1:0] b;
    b = '0;
    b[WIDTH-1] = g[WIDTH-1];
    for (int i = int'(WIDTH) - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  assign sample = gray2bin(bus.gray_in);

  // Registered state; the reference sample doubles as binary_out since both
  // update and hold together.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= UNLOCKED;
      ref_q   <= '0;
      bv_q    <= 1'b0;
      up_q    <= 1'b0;
      dn_q    <= 1'b0;
      er_q    <= 1'b0;
      pos_q   <= '0;
      err_q   <= '0;
    end else begin
      state_q <= state_d;
      ref_q   <= ref_d;
      bv_q    <= bv_d;
      up_q    <= up_d;
      dn_q    <= dn_d;
      er_q    <= er_d;
      pos_q   <= pos_d;
      err_q   <= err_d;
    end
  end

  // Next-state and classification of the incoming sample.
  always_comb begin
    state_d = state_q;
    ref_d   = ref_q;
    bv_d    = 1'b0;
    up_d    = 1'b0;
    dn_d    = 1'b0;
    er_d    = 1'b0;
    pos_d   = pos_q;
    err_d   = err_q;

    if (bus.gray_valid) begin
      unique case (state_q)
        UNLOCKED: begin
          ref_d   = sample;
          bv_d    = 1'b1;
          state_d = LOCKED;
        end
        LOCKED: begin
          if (sample == ref_q) begin
            bv_d = 1'b1;
          end else if (sample == ref_q + WIDTH'(1)) begin
            ref_d = sample;
            bv_d  = 1'b1;
            up_d  = 1'b1;
            pos_d = pos_q + POS_W'(1);
          end else if (sample == ref_q - WIDTH'(1)) begin
            ref_d = sample;
            bv_d  = 1'b1;
            dn_d  = 1'b1;
            pos_d = pos_q - POS_W'(1);
          end else begin
            er_d    = 1'b1;
            state_d = UNLOCKED;
            if (err_q != ERR_MAX) begin
              err_d = err_q + ERR_CNT_W'(1);
            end
          end
        end
        default: state_d = UNLOCKED;
      endcase
    end

    // Clear overrides any simultaneous count update.
    if (bus.clear) begin
      pos_d = '0;
      err_d = '0;
    end
  end

  assign bus.binary_out   = ref_q;
  assign bus.binary_valid = bv_q;
  assign bus.step_up      = up_q;
  assign bus.step_down    = dn_q;
  assign bus.step_err     = er_q;
  assign bus.locked       = (state_q == LOCKED);
  assign bus.pos_count    = pos_q;
  assign bus.err_count    = err_q;

endmodule

// File: tb/tb_gray_stream_decoder.sv
// Directed and random stimulus for gray_stream_decoder against an arithmetic
// model of the sample classification rules.
module tb_gray_stream_decoder;

  localparam int unsigned WIDTH     = 4;
  localparam int unsigned POS_W     = 16;
  localparam int unsigned ERR_CNT_W = 8;
  localparam int MOD      = 1 << WIDTH;
  localparam int POS_MASK = (1 << POS_W) - 1;
  localparam int ERR_MAX  = (1 << ERR_CNT_W) - 1;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  gray_stream_decoder_if #(.WIDTH(WIDTH), .POS_W(POS_W), .ERR_CNT_W(ERR_CNT_W)) bus ();

  gray_stream_decoder #(.WIDTH(WIDTH), .POS_W(POS_W), .ERR_CNT_W(ERR_CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int tests = 0;
  int fails = 0;

  // Reference model state
  bit m_locked;
  int m_ref;
  int m_pos;
  int m_err;
  bit e_bv, e_up, e_dn, e_er;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s at %0t: got %0d, expected %0d", tag, $time, got, exp);
    end
  endtask

  function automatic void model_reset();
    m_locked = 1'b0;
    m_ref = 0; m_pos = 0; m_err = 0;
    e_bv = 0; e_up = 0; e_dn = 0; e_er = 0;
  endfunction

  function automatic void model_apply(input bit v, input int b, input bit clr);
    int d;
    e_bv = 0; e_up = 0; e_dn = 0; e_er = 0;
    if (v) begin
      if (!m_locked) begin
        m_ref = b; e_bv = 1; m_locked = 1;
      end else begin
        d = (b - m_ref + MOD) % MOD;
        if (d == 0) begin
          e_bv = 1;
        end else if (d == 1) begin
          e_bv = 1; e_up = 1; m_ref = b; m_pos = m_pos + 1;
        end else if (d == MOD - 1) begin
          e_bv = 1; e_dn = 1; m_ref = b; m_pos = m_pos - 1;
        end else begin
          e_er = 1; m_locked = 0;
          if (m_err < ERR_MAX) m_err = m_err + 1;
        end
      end
    end
    if (clr) begin
      m_pos = 0; m_err = 0;
    end
  endfunction

  // One clock: drive on the falling edge, check 1 time unit after the rising edge.
  task automatic step(input bit v, input int b, input bit clr, input bit r);
    int g;
    g = b ^ (b >> 1);
    @(negedge clk);
    rst            = r;
    bus.gray_valid = v;
    bus.gray_in    = WIDTH'(g);
    bus.clear      = clr;
    @(posedge clk);
    #1;
    if (r) model_reset();
    else   model_apply(v, b, clr);
    check_eq("binary_out",   32'(bus.binary_out),   32'(m_ref));
    check_eq("binary_valid", 32'(bus.binary_valid), 32'(e_bv));
    check_eq("step_up",      32'(bus.step_up),      32'(e_up));
    check_eq("step_down",    32'(bus.step_down),    32'(e_dn));
    check_eq("step_err",     32'(bus.step_err),     32'(e_er));
    check_eq("locked",       32'(bus.locked),       32'(m_locked));
    check_eq("pos_count",    32'(bus.pos_count),    32'(m_pos & POS_MASK));
    check_eq("err_count",    32'(bus.err_count),    32'(m_err));
  endtask

  task automatic sample(input int b);
    step(1'b1, b, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    step(1'b0, 0, 1'b0, 1'b1);
  endtask

  initial begin
    int r, b, d;
    bus.gray_valid = 1'b0;
    bus.gray_in    = '0;
    bus.clear      = 1'b0;
    model_reset();

    // Counting up from zero
    do_reset();
    sample(0); sample(1); sample(2); sample(3);
    step(1'b0, 0, 1'b0, 1'b0);

    // Wrap in both directions
    do_reset();
    sample(15); sample(0); sample(15);

    // Illegal jump, then relock
    do_reset();
    sample(1); sample(5); sample(4);

    // Hamming-1 but not sequence-adjacent
    do_reset();
    sample(0); sample(7);

    // Error saturation and clear priority
    do_reset();
    for (int i = 0; i < 300; i++) begin
      sample(0); sample(8);
    end
    sample(0);
    step(1'b1, 8, 1'b1, 1'b0);
    sample(0);
    step(1'b1, 1, 1'b1, 1'b0);
    sample(2);

    // Reset mid-stream
    do_reset();
    for (int i = 0; i < 6; i++) sample(i);
    do_reset();
    sample(2);

    // Random traffic biased toward legal steps
    for (int i = 0; i < 3000; i++) begin
      r = int'($urandom_range(0, 99));
      if (r < 2) begin
        do_reset();
      end else begin
        if ($urandom_range(0, 99) < 70) begin
          d = int'($urandom_range(0, 2)) - 1;
          b = (m_ref + d + MOD) % MOD;
        end else begin
          b = int'($urandom_range(0, MOD - 1));
        end
        step(r < 80, b, $urandom_range(0, 99) < 3, 1'b0);
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
